// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the pipelined ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRA = 4'd6,
    OP_SRL = 4'd7,
    OP_MUL = 4'd8,
    OP_SLT = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits of the product.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             busy;

  // Two's complement makes the low WIDTH bits of the unsigned product equal the signed one.
  assign done = busy && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      count   <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      mcand   <= a;
      mplier  <= b;
      product <= '0;
      count   <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) begin
        product <= product + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready handshake, registered result and flags,
// and a multi-cycle multiply handled by an IDLE/MUL/DONE controller.
module alu_pipe #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] MATCH_VALUE = WIDTH'(32'hABCD)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUcontrol,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Output,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             MATCH,
  output logic             ILL
);

  import alu_pkg::*;

  localparam int SW = $clog2(WIDTH);

  alu_state_t       state, state_next;
  alu_op_t          op;
  logic             accept, is_mul, load, mul_start, mul_done;
  logic [WIDTH-1:0] mul_product, alu_res, res_next, diff;
  logic [WIDTH:0]   sum_ext;
  logic [SW-1:0]    shamt;
  logic             alu_c, alu_v, alu_ill, c_next, v_next, ill_next;

  assign op        = alu_op_t'(ALUcontrol);
  assign is_mul    = (op == OP_MUL);
  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul;
  assign load      = (accept && !is_mul) || (state == DONE);
  assign shamt     = B[SW-1:0];
  assign sum_ext   = {1'b0, A} + {1'b0, B};
  assign diff      = A - B;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle operations; illegal opcodes fall through to a zero result.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = (A < B);
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLL:  alu_res = A << shamt;
      OP_SRA:  alu_res = $signed(A) >>> shamt;
      OP_SRL:  alu_res = A >> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    res_next = alu_res;
    c_next   = alu_c;
    v_next   = alu_v;
    ill_next = alu_ill;
    if (state == DONE) begin
      res_next = mul_product;
      c_next   = 1'b0;
      v_next   = 1'b0;
      ill_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE lasts one cycle so the finished product is stable when it is loaded.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = MUL;
      MUL:     if (mul_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      Output    <= '0;
      Z         <= 1'b0;
      N         <= 1'b0;
      C         <= 1'b0;
      V         <= 1'b0;
      MATCH     <= 1'b0;
      ILL       <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      Output    <= res_next;
      Z         <= (res_next == '0);
      N         <= res_next[WIDTH-1];
      C         <= c_next;
      V         <= v_next;
      MATCH     <= (res_next == MATCH_VALUE);
      ILL       <= ill_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized traffic
// scored against an arithmetic reference model.
module tb_alu_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   ALUcontrol = 4'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         in_ready, out_valid, Z, N, C, V, MATCH, ILL;
  logic [W-1:0] Output;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] res;
    logic z, n, c, v, m, ill;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic [5:0]  fl;
  } vec_t;

  alu_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUcontrol(ALUcontrol), .A(A), .B(B), .out_valid(out_valid),
    .out_ready(out_ready), .Output(Output), .Z(Z), .N(N), .C(C), .V(V),
    .MATCH(MATCH), .ILL(ILL)
  );

  always #5 clk = ~clk;

  // Reference behaviour derived from plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, wide;
    logic [32:0] usum;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = '0;
    case (op)
      4'd0: begin
        usum  = {1'b0, a} + {1'b0, b};
        e.res = usum[31:0];
        e.c   = usum[32];
        wide  = sa + sb;
        e.v   = (wide > 64'sh7FFFFFFF) || (wide < -64'sh80000000);
      end
      4'd1: begin
        e.res = a - b;
        e.c   = (a < b);
        wide  = sa - sb;
        e.v   = (wide > 64'sh7FFFFFFF) || (wide < -64'sh80000000);
      end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = a << b[4:0];
      4'd6: e.res = 32'(sa >>> b[4:0]);
      4'd7: e.res = a >> b[4:0];
      4'd8: e.res = 32'(sa * sb);
      4'd9: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    e.n = e.res[31];
    e.m = (e.res == 32'hABCD);
    return e;
  endfunction

  function automatic exp_t observed();
    return exp_t'({Output, Z, N, C, V, MATCH, ILL});
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h7FFFFFFF;
      4: return 32'h80000000;
      5: return 32'hABCD;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid   = v;
    ALUcontrol = op;
    A          = a;
    B          = b;
  endtask

  task automatic test_reset();
    exp_t got;
    reset_n   = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (2) tick();
    got = observed();
    n_cmp++;
    if (out_valid !== 1'b0 || got !== exp_t'(0)) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got valid=%b out=%h flags=%b, required valid=0 out=0 flags=0",
               out_valid, got.res, got[5:0]);
    end
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [6];
    exp_t got, e;
    want = '{32'd50, 32'd10, 32'd20, 32'd30, 32'd10, 32'd31457280};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'(i), 32'd30, 32'd20);
      tick();
      got = observed();
      e   = model(4'(i), 32'd30, 32'd20);
      n_cmp++;
      if (out_valid !== 1'b1 || got.res !== want[i] || got !== e || in_ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL b2b_op%0d: got valid=%b ready=%b out=%0d flags=%b, required valid=1 ready=1 out=%0d flags=%b",
                 i, out_valid, in_ready, got.res, got[5:0], want[i], e[5:0]);
      end
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_flags();
    vec_t vecs [9];
    exp_t got;
    vecs = '{
      '{4'd6,  32'hFFFFFFFC, 32'd1,         32'hFFFFFFFE, 6'b010000},
      '{4'd7,  32'hFFFFFFFC, 32'd1,         32'h7FFFFFFE, 6'b000000},
      '{4'd0,  32'hFFFFFFFC, 32'd4,         32'h00000000, 6'b101000},
      '{4'd0,  32'h0000ABCD, 32'd0,         32'h0000ABCD, 6'b000010},
      '{4'd0,  32'h7FFFFFFF, 32'd1,         32'h80000000, 6'b010100},
      '{4'd1,  32'h00000000, 32'd1,         32'hFFFFFFFF, 6'b011000},
      '{4'd12, 32'h00001234, 32'h00005678,  32'h00000000, 6'b100001},
      '{4'd9,  32'hFFFFFFFB, 32'd3,         32'h00000001, 6'b000000},
      '{4'd5,  32'h00000001, 32'h00000123,  32'h00000008, 6'b000000}
    };
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      got = observed();
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp_t'({vecs[i].res, vecs[i].fl})) begin
        n_fail++;
        $display("[TB] FAIL flags_vec%0d: got valid=%b out=%h zncvmi=%b, required valid=1 out=%h zncvmi=%b",
                 i, out_valid, got.res, got[5:0], vecs[i].res, vecs[i].fl);
      end
    end
    tick();
  endtask

  task automatic test_mul();
    exp_t got, e;
    int   bad_k;
    out_ready = 1'b1;
    bad_k     = -1;
    drive(1'b1, 4'd8, 32'd7, 32'hFFFFFFFD);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    for (int k = 0; k <= W; k++) begin
      if ((out_valid !== 1'b0 || in_ready !== 1'b0) && bad_k < 0) bad_k = k;
      tick();
    end
    n_cmp++;
    if (bad_k >= 0) begin
      n_fail++;
      $display("[TB] FAIL mul_busy_window: got valid/ready high at cycle %0d after accept, required both low", bad_k + 1);
    end
    got = observed();
    e   = model(4'd8, 32'd7, 32'hFFFFFFFD);
    n_cmp++;
    if (out_valid !== 1'b1 || got.res !== 32'hFFFFFFEB || got !== e) begin
      n_fail++;
      $display("[TB] FAIL mul_result: got valid=%b out=%h flags=%b, required valid=1 out=ffffffeb flags=%b",
               out_valid, got.res, got[5:0], e[5:0]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    exp_t        got, e1, e2;
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom; a2 = pick(); b2 = pick();
    e1 = model(4'd4, a1, b1);
    e2 = model(4'd0, a2, b2);
    out_ready = 1'b0;
    drive(1'b1, 4'd4, a1, b1);
    tick();
    drive(1'b1, 4'd0, a2, b2);
    for (int k = 0; k < 5; k++) begin
      got = observed();
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== e1) begin
        n_fail++;
        $display("[TB] FAIL stall_cycle%0d: got valid=%b ready=%b out=%h flags=%b, required valid=1 ready=0 out=%h flags=%b",
                 k, out_valid, in_ready, got.res, got[5:0], e1.res, e1[5:0]);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stall_release_ready: got in_ready=%b required 1", in_ready);
    end
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    got = observed();
    n_cmp++;
    if (out_valid !== 1'b1 || got !== e2) begin
      n_fail++;
      $display("[TB] FAIL drain_and_accept: got valid=%b out=%h flags=%b, required valid=1 out=%h flags=%b",
               out_valid, got.res, got[5:0], e2.res, e2[5:0]);
    end
    tick();
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        got, e;
    logic [3:0]  op;
    int          guard;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd8 && $urandom_range(0, 3) != 0) op = 4'd0;
      drive(1'($urandom_range(0, 1)), op, pick(), pick());
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL rand_stall_ready cyc%0d: got in_ready=%b required 0", cyc, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        got = observed();
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL rand_spurious cyc%0d: got out=%h with nothing outstanding, required no result", cyc, got.res);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("[TB] FAIL rand_result cyc%0d: got out=%h flags=%b, required out=%h flags=%b",
                     cyc, got.res, got[5:0], e.res, e[5:0]);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(ALUcontrol, A, B));
      @(posedge clk);
      #1;
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 100) begin
      @(negedge clk);
      if (out_valid && q.size() != 0) begin
        got = observed();
        e   = q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_fail++;
          $display("[TB] FAIL rand_tail: got out=%h flags=%b, required out=%h flags=%b",
                   got.res, got[5:0], e.res, e[5:0]);
        end
      end
      @(posedge clk);
      #1;
      guard++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL rand_outstanding: got %0d results never delivered, required 0", q.size());
    end
  endtask

  task automatic test_reset_mid_mul();
    exp_t got;
    int   bad_k;
    out_ready = 1'b1;
    bad_k     = -1;
    drive(1'b1, 4'd0, 32'd5, 32'd6);
    tick();
    drive(1'b1, 4'd8, pick(), 32'd3);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (10) tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || Output !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_mul: got valid=%b out=%h, required valid=0 out=0", out_valid, Output);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < W + 5; k++) begin
      if (out_valid !== 1'b0 && bad_k < 0) bad_k = k;
      tick();
    end
    n_cmp++;
    if (bad_k >= 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mul_aborted: got stale result at cycle %0d, in_ready=%b, required no result and in_ready=1",
               bad_k, in_ready);
    end
    drive(1'b1, 4'd12, pick(), pick());
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    got = observed();
    n_cmp++;
    if (out_valid !== 1'b1 || got !== exp_t'({32'd0, 6'b100001})) begin
      n_fail++;
      $display("[TB] FAIL illegal_after_reset: got valid=%b out=%h zncvmi=%b, required valid=1 out=0 zncvmi=100001",
               out_valid, got.res, got[5:0]);
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_flags();
    test_mul();
    test_backpressure();
    test_random();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=8, power of 2).
REQ-002 SHALL have parameter MATCH_VALUE, default 32'hABCD (WIDTH bits), constant compared against the result for the MATCH flag.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operation request valid.
REQ-007 in_ready  output  1  block accepts request this cycle.
REQ-008 ALUcontrol  input  4  opcode.
REQ-009 A, B  input  WIDTH each  signed operands.
REQ-010 out_valid  output  1  Output and flags valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 Output  output  WIDTH  signed result.
REQ-013 Z, N, C, V, MATCH, ILL  output  1 each  zero, negative, carry/borrow, signed overflow, result==MATCH_VALUE, illegal opcode.

Function
REQ-014 Opcodes SHALL be: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRA, 7 SRL, 8 MUL, 9 SLT (signed, result 1/0); 10-15 illegal.
REQ-015 Shift amount SHALL be B[log2(WIDTH)-1:0]; upper B bits ignored.
REQ-016 MUL SHALL return the low WIDTH bits of the signed product, computed iteratively by shift-add, one partial product per cycle.
REQ-017 A request SHALL be accepted on a cycle with in_valid && in_ready; A, B, ALUcontrol SHALL be captured at acceptance.
REQ-018 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-019 Non-MUL ops SHALL have 1-cycle latency: out_valid and result registered on the edge following acceptance; throughput one per cycle under continuous out_ready.
REQ-020 FSM states SHALL be IDLE, MUL, DONE: IDLE->MUL on accepted MUL; MUL holds for exactly WIDTH cycles (counter 0..WIDTH-1); MUL->DONE loads the output register, sets out_valid; DONE->IDLE same edge (DONE is one cycle, in_ready low).
REQ-021 While out_valid && !out_ready, Output, flags and out_valid SHALL hold unchanged and in_ready SHALL be 0.
REQ-022 out_valid SHALL clear on out_ready unless a new result is loaded the same edge (simultaneous accept and drain SHALL both occur).
REQ-023 Z = (Output==0); N = Output[WIDTH-1]; MATCH = (Output==MATCH_VALUE), for every op.
REQ-024 C SHALL be the carry out for ADD, borrow (A<B unsigned) for SUB, 0 otherwise.
REQ-025 V SHALL be signed overflow for ADD/SUB, 0 otherwise; arithmetic wraps modulo 2^WIDTH.
REQ-026 Illegal opcode SHALL complete in 1 cycle with Output=0, ILL=1, Z=1, other flags 0; ILL=0 for legal ops.

Reset
REQ-027 Asserting reset_n low SHALL immediately set state=IDLE, counter=0, out_valid=0, Output=0, all flags 0; in_ready SHALL be 1 after release.
REQ-028 Reset during MUL SHALL abort the operation with no result produced.

Structure
REQ-029 Opcode encodings and FSM state encoding SHALL live in shared package alu_pkg.
REQ-030 The iterative multiplier (datapath + counter) SHALL be sub-module alu_mul_seq with start/done handshake; FSM, output register and flags stay in alu_pipe.

Verification
REQ-031 A=30, B=20, ops 0..5, out_ready=1 back-to-back -> Output 50, 10, 20, 30, 10, 31457280 on consecutive cycles, one cycle after each accept.
REQ-032 A=-4, B=1, op 6 -> -2, N=1; op 7 -> 32'h7FFFFFFE; A=-4, B=4, op 0 -> 0, Z=1, C=1; A=32'hABCD, B=0, op 0 -> MATCH=1.
REQ-033 A=32'h7FFFFFFF, B=1, op 0 -> 32'h80000000, V=1, N=1; A=0, B=1, op 1 -> -1, C=1.
REQ-034 A=7, B=-3, op 8 -> -21, out_valid exactly WIDTH+1 cycles after accept, in_ready low throughout.
REQ-035 out_ready=0 for 5 cycles after a result -> Output/flags stable, in_ready=0, no new accept; then out_ready=1 with in_valid -> drain and accept same cycle.
REQ-036 reset_n low mid-MUL -> out_valid=0, Output=0 immediately; next op 12 -> ILL=1, Output=0.
